// File: rtl/rf_writeback_ctrl.sv
// Register file writeback port owner: merges ALU and buffered LSU results into one
// registered write per cycle and tracks pending long-latency destinations for decode.
module rf_writeback_ctrl #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_dst_i,
    input  logic [31:0] alu_data_i,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [4:0]  lsu_dst_i,
    input  logic [31:0] lsu_data_i,
    input  logic        issue_valid_i,
    input  logic [4:0]  issue_dst_i,
    input  logic [4:0]  read_reg1_sel_i,
    input  logic [4:0]  read_reg2_sel_i,
    output logic        rs1_busy_o,
    output logic        rs2_busy_o,
    output logic        drain_req_o,
    output logic        write_enable_o,
    output logic [4:0]  reg_write_dst_o,
    output logic [31:0] write_data_o
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic [4:0]    fifo_dst  [FIFO_DEPTH];
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   pending_q, pending_d;

    logic        we_d;
    logic [4:0]  dst_d;
    logic [31:0] data_d;

    logic fifo_empty, lsu_acc, deq, bypass, enq;
    logic [4:0] lsu_wb_dst;
    logic [31:0] set_mask, clr_mask;

    assign fifo_empty  = (count_q == '0);
    assign lsu_ready_o = (count_q < CW'(FIFO_DEPTH));
    assign lsu_acc     = lsu_valid_i && lsu_ready_o;
    assign deq         = !alu_valid_i && !fifo_empty;
    assign bypass      = !alu_valid_i && fifo_empty && lsu_acc;
    assign enq         = lsu_acc && !bypass;
    assign lsu_wb_dst  = deq ? fifo_dst[rd_ptr_q] : lsu_dst_i;

    assign rs1_busy_o  = pending_q[read_reg1_sel_i];
    assign rs2_busy_o  = pending_q[read_reg2_sel_i];
    assign drain_req_o = (count_q == CW'(FIFO_DEPTH)) || (starve_q == SW'(STARVE_MAX));

    always_comb begin
        we_d   = 1'b0;
        dst_d  = reg_write_dst_o;
        data_d = write_data_o;
        if (alu_valid_i) begin
            we_d   = (alu_dst_i != 5'd0);
            dst_d  = alu_dst_i;
            data_d = alu_data_i;
        end else if (deq) begin
            we_d   = (fifo_dst[rd_ptr_q] != 5'd0);
            dst_d  = fifo_dst[rd_ptr_q];
            data_d = fifo_data[rd_ptr_q];
        end else if (bypass) begin
            we_d   = (lsu_dst_i != 5'd0);
            dst_d  = lsu_dst_i;
            data_d = lsu_data_i;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || deq) begin
            starve_d = '0;
        end else if (alu_valid_i && (starve_q != SW'(STARVE_MAX))) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Set is applied after clear so a same-cycle issue to the same register wins.
    always_comb begin
        set_mask  = (issue_valid_i && (issue_dst_i != 5'd0)) ? (32'd1 << issue_dst_i) : 32'd0;
        clr_mask  = (deq || bypass) ? (32'd1 << lsu_wb_dst) : 32'd0;
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
            starve_q        <= '0;
            pending_q       <= '0;
            write_enable_o  <= 1'b0;
            reg_write_dst_o <= 5'd0;
            write_data_o    <= 32'd0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (deq) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q         <= count_d;
            starve_q        <= starve_d;
            pending_q       <= pending_d;
            write_enable_o  <= we_d;
            reg_write_dst_o <= dst_d;
            write_data_o    <= data_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            fifo_dst[wr_ptr_q]  <= lsu_dst_i;
            fifo_data[wr_ptr_q] <= lsu_data_i;
        end
    end

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Scoreboard bench for rf_writeback_ctrl: expected writes are queued at drive time
// and compared one cycle later, with directed checks on ready, drain and busy.
module tb_rf_writeback_ctrl;

    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic        we;
        logic [4:0]  dst;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [4:0]  dst;
        logic [31:0] data;
    } ent_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        alu_valid_i, lsu_valid_i, issue_valid_i;
    logic [4:0]  alu_dst_i, lsu_dst_i, issue_dst_i, read_reg1_sel_i, read_reg2_sel_i;
    logic [31:0] alu_data_i, lsu_data_i;
    logic        lsu_ready_o, rs1_busy_o, rs2_busy_o, drain_req_o, write_enable_o;
    logic [4:0]  reg_write_dst_o;
    logic [31:0] write_data_o;

    int   n_cmp = 0;
    int   n_err = 0;
    wr_t  exp_q[$];
    ent_t mq[$];
    logic [31:0] mpend = 32'd0;

    rf_writeback_ctrl #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(4)) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .alu_valid_i     (alu_valid_i),
        .alu_dst_i       (alu_dst_i),
        .alu_data_i      (alu_data_i),
        .lsu_valid_i     (lsu_valid_i),
        .lsu_ready_o     (lsu_ready_o),
        .lsu_dst_i       (lsu_dst_i),
        .lsu_data_i      (lsu_data_i),
        .issue_valid_i   (issue_valid_i),
        .issue_dst_i     (issue_dst_i),
        .read_reg1_sel_i (read_reg1_sel_i),
        .read_reg2_sel_i (read_reg2_sel_i),
        .rs1_busy_o      (rs1_busy_o),
        .rs2_busy_o      (rs2_busy_o),
        .drain_req_o     (drain_req_o),
        .write_enable_o  (write_enable_o),
        .reg_write_dst_o (reg_write_dst_o),
        .write_data_o    (write_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs, predict the write, step the clock, then compare.
    task automatic step(input logic av, input logic [4:0] ad, input logic [31:0] adata,
                        input logic lv, input logic [4:0] ld, input logic [31:0] ldata,
                        input logic iv, input logic [4:0] id);
        logic acc;
        wr_t  e;
        ent_t h, got;
        alu_valid_i = av; alu_dst_i = ad; alu_data_i = adata;
        lsu_valid_i = lv; lsu_dst_i = ld; lsu_data_i = ldata;
        issue_valid_i = iv; issue_dst_i = id;
        #1;
        check_val("lsu_ready", 32'(lsu_ready_o), 32'(mq.size() < DEPTH));
        acc = lv && (mq.size() < DEPTH);
        e = '0;
        if (av) begin
            e = '{we: (ad != 5'd0), dst: ad, data: adata};
            if (acc) mq.push_back('{dst: ld, data: ldata});
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            e = '{we: (h.dst != 5'd0), dst: h.dst, data: h.data};
            mpend[h.dst] = 1'b0;
            if (acc) mq.push_back('{dst: ld, data: ldata});
        end else if (acc) begin
            e = '{we: (ld != 5'd0), dst: ld, data: ldata};
            mpend[ld] = 1'b0;
        end
        if (iv && id != 5'd0) mpend[id] = 1'b1;
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        if (exp_q.size() == 0) begin
            check_val("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_val("write_enable", 32'(write_enable_o), 32'(e.we));
            if (e.we) begin
                got = '{dst: reg_write_dst_o, data: write_data_o};
                check_val("write_dst", 32'(got.dst), 32'(e.dst));
                check_val("write_data", got.data, e.data);
            end
        end
        check_val("rs1_busy", 32'(rs1_busy_o), 32'(mpend[read_reg1_sel_i]));
        check_val("rs2_busy", 32'(rs2_busy_o), 32'(mpend[read_reg2_sel_i]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n_i = 1'b0;
        alu_valid_i = 0; alu_dst_i = 0; alu_data_i = 0;
        lsu_valid_i = 0; lsu_dst_i = 0; lsu_data_i = 0;
        issue_valid_i = 0; issue_dst_i = 0;
        read_reg1_sel_i = 5'd7; read_reg2_sel_i = 5'd9;
        #12;
        check_val("rst_we", 32'(write_enable_o), 32'd0);
        check_val("rst_dst", 32'(reg_write_dst_o), 32'd0);
        check_val("rst_data", write_data_o, 32'd0);
        check_val("rst_ready", 32'(lsu_ready_o), 32'd1);
        check_val("rst_drain", 32'(drain_req_o), 32'd0);
        check_val("rst_busy", 32'({rs1_busy_o, rs2_busy_o}), 32'd0);
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;

        // Single ALU write, then idle.
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        idle(1);

        // Long-latency issue to r7, LSU bypass writeback clears busy in write cycle.
        step(0, 0, 0, 0, 0, 0, 1, 7);
        idle(2);
        step(0, 0, 0, 1, 7, 32'h12345678, 0, 0);
        idle(1);

        // Fill FIFO behind continuous ALU traffic, then drain in order.
        step(1, 10, 32'hA0A0_0001, 1, 3, 32'h0000_0333, 0, 0);
        step(1, 11, 32'hA0A0_0002, 1, 4, 32'h0000_0444, 0, 0);
        check_val("full_ready", 32'(lsu_ready_o), 32'd0);
        check_val("full_drain", 32'(drain_req_o), 32'd1);
        step(1, 12, 32'hA0A0_0003, 1, 8, 32'h0000_0888, 0, 0);
        idle(2);
        check_val("drained_ready", 32'(lsu_ready_o), 32'd1);
        check_val("drained_drain", 32'(drain_req_o), 32'd0);

        // Starvation: one entry blocked by ALU; drain request after four blocked cycles.
        step(1, 13, 32'hB000_0000, 1, 6, 32'h0000_0666, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            step(1, 13, 32'hB000_0000 + 32'(k), 0, 0, 0, 0, 0);
            check_val($sformatf("starve_drain_%0d", k), 32'(drain_req_o), 32'(k >= 4));
        end
        idle(1);
        check_val("starve_cleared", 32'(drain_req_o), 32'd0);

        // Destination zero from both sources: consumed, never written.
        step(1, 0, 32'hFFFF_FFFF, 1, 0, 32'h0BAD_0000, 0, 0);
        idle(1);
        step(0, 0, 0, 1, 0, 32'h0BAD_0001, 1, 0);
        idle(1);

        // Same-cycle issue and writeback of r9: pending stays set.
        step(0, 0, 0, 0, 0, 0, 1, 9);
        step(0, 0, 0, 1, 9, 32'h9999_9999, 1, 9);
        idle(1);

        // Asynchronous reset mid-stream discards FIFO and pending state.
        step(1, 14, 32'hC000_0001, 1, 20, 32'h2020_2020, 1, 7);
        step(1, 15, 32'hC000_0002, 1, 21, 32'h2121_2121, 0, 0);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_val("mid_rst_we", 32'(write_enable_o), 32'd0);
        check_val("mid_rst_dst", 32'(reg_write_dst_o), 32'd0);
        check_val("mid_rst_data", write_data_o, 32'd0);
        check_val("mid_rst_ready", 32'(lsu_ready_o), 32'd1);
        check_val("mid_rst_drain", 32'(drain_req_o), 32'd0);
        check_val("mid_rst_busy", 32'({rs1_busy_o, rs2_busy_o}), 32'd0);
        mq.delete();
        exp_q.delete();
        mpend = 32'd0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        idle(2);
        step(0, 0, 0, 1, 22, 32'h2222_2222, 0, 0);
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_writeback_ctrl.md
# rf_writeback_ctrl

Writeback-side controller that owns the register file's write port. It merges single-cycle ALU results with long-latency LSU results, buffers LSU results in a small FIFO, and drives one registered write per cycle into the register file. It also keeps a pending-write scoreboard that decode queries to stall on long-latency RAW hazards. It sits between the execute/memory stages and the register file.

## Interface

- FIFO_DEPTH, 2: LSU result buffer entries (power of two, ≥2).
- STARVE_MAX, 4: consecutive cycles a non-empty FIFO head may be blocked by ALU traffic before drain_req_o asserts.

- clk_i  in  1  clock; all state on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- alu_valid_i  in  1  ALU result valid this cycle; cannot be backpressured.
- alu_dst_i  in  5  ALU destination register.
- alu_data_i  in  32  ALU result.
- lsu_valid_i  in  1  LSU result valid.
- lsu_ready_o  out  1  LSU result accepted when lsu_valid_i && lsu_ready_o.
- lsu_dst_i  in  5  LSU destination register.
- lsu_data_i  in  32  LSU result.
- issue_valid_i  in  1  long-latency instruction issued; marks issue_dst_i pending.
- issue_dst_i  in  5  destination of issued long-latency instruction.
- read_reg1_sel_i  in  5  decode source 1 query.
- read_reg2_sel_i  in  5  decode source 2 query.
- rs1_busy_o  out  1  pending[read_reg1_sel_i], combinational.
- rs2_busy_o  out  1  pending[read_reg2_sel_i], combinational.
- drain_req_o  out  1  request to pipeline control to insert an ALU bubble.
- write_enable_o  out  1  register file write enable (registered).
- reg_write_dst_o  out  5  register file write address (registered).
- write_data_o  out  32  register file write data (registered).

## Operation

- Reset: write_enable_o=0, reg_write_dst_o=0, write_data_o=0, pending=0, FIFO empty, starvation counter 0; lsu_ready_o=1, drain_req_o=0, busy outputs 0.
- Priority per cycle for the single output slot: ALU > FIFO head > LSU bypass.
  - alu_valid_i=1: ALU result loads output register. An accepted LSU result enqueues.
  - alu_valid_i=0, FIFO non-empty: head dequeues to output register. An accepted LSU result enqueues in the same cycle; FIFO order is preserved.
  - alu_valid_i=0, FIFO empty, LSU handshake: LSU result bypasses straight to output register.
  - nothing: write_enable_o=0 next cycle; dst/data hold their last values.
- lsu_ready_o = (count < FIFO_DEPTH). It depends only on state, not on lsu_valid_i. A simultaneous dequeue does not raise ready in the same cycle when full.
- Destination 0: the result is consumed (dequeued/accepted) but write_enable_o stays 0 for that slot. No pending bit is ever set for register 0.
- Scoreboard: 32-bit pending vector.
  - Set on issue_valid_i when issue_dst_i≠0.
  - Cleared when an LSU-sourced result (bypass or dequeue) for that register loads the output register.
  - Same-cycle set and clear of the same register: set wins.
  - ALU writes never change pending bits.
  - Preventing a WAW between ALU and a pending LSU destination is an upstream responsibility; an ALU write is always performed.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and alu_valid_i=1.
  - Clears on any dequeue or when the FIFO is empty; saturates at STARVE_MAX.
- drain_req_o = (count==FIFO_DEPTH) || (counter==STARVE_MAX).

## Timing

- ALU result at cycle N → write_enable_o at N+1.
- LSU handshake at N with FIFO empty and alu_valid_i=0 → write at N+1 (bypass).
- FIFO entry: written out at cycle M+1, where M is the first cycle with alu_valid_i=0 and that entry at the head.
- Pending bit set at N (issue) → busy visible at N+1. Cleared at the edge that loads write_enable_o, so busy drops in the same cycle write_enable_o=1.
- Throughput: one write per cycle. The LSU accepts one result per cycle while count<FIFO_DEPTH.
- Reset asserted mid-operation: all state clears immediately (asynchronous); FIFO contents and pending bits are discarded.

## Test plan

- Reset, then alu_valid_i=1, dst=5, data=0xDEADBEEF at N → write_enable_o=1, reg_write_dst_o=5, write_data_o=0xDEADBEEF at N+1; 0 at N+2.
- issue dst=7; later LSU dst=7, data=0x12345678 with ALU idle → rs1_busy_o=1 (sel=7) from issue+1 until the write cycle; write at handshake+1, busy=0 in that cycle.
- ALU valid every cycle, two LSU results (dst 3, 4) → lsu_ready_o=0 after the second; drain_req_o=1. Then ALU drops for two cycles → writes dst 3 then dst 4 in order, ready returns to 1.
- One FIFO entry, ALU valid continuously → drain_req_o=1 exactly STARVE_MAX=4 cycles after blocking begins; clears after the dequeue.
- LSU result to dst 0, and ALU result to dst 0 → entries consumed, write_enable_o stays 0, pending unchanged.
- Same-cycle issue dst=9 and LSU writeback dst=9 → pending[9] stays 1; rst_n_i pulled low mid-stream → all outputs 0 and FIFO empty immediately.
